// File: rtl/mul_share_sched_if.sv
// Request/grant/response bundle between NUM_REQ datapath requesters and the
// shared multiplier scheduler.
interface mul_share_sched_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] opa;
  logic [NUM_REQ*WIDTH-1:0] opb;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         result;
  logic                     busy;

  modport master (
    output req, opa, opb,
    input  gnt, rsp_valid, result, busy
  );

  modport slave (
    input  req, opa, opb,
    output gnt, rsp_valid, result, busy
  );
endinterface

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one signed WIDTH-bit multiplier among NUM_REQ
// requesters; one operation in flight, result returned MUL_LAT cycles after grant.
module mul_share_sched #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_share_sched_if.slave  bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MUL_LAT) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      rr_reg, rr_next;
  logic [PW-1:0]      owner_reg, owner_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [WIDTH-1:0]   opa_reg, opa_next;
  logic [WIDTH-1:0]   opb_reg, opb_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [NUM_REQ-1:0] rsp_reg, rsp_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               busy_reg, busy_next;

  logic [WIDTH-1:0]   opa_slice [NUM_REQ];
  logic [WIDTH-1:0]   opb_slice [NUM_REQ];
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic signed [2*WIDTH-1:0] full_prod;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign opa_slice[gi] = bus.opa[gi*WIDTH +: WIDTH];
      assign opb_slice[gi] = bus.opb[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First requesting index at or after rr_reg, wrapping to 0.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Truncation to the low WIDTH bits gives wrap-around signed semantics.
  assign full_prod = $signed(opa_reg) * $signed(opb_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_reg     <= '0;
      owner_reg  <= '0;
      cnt_reg    <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      gnt_reg    <= '0;
      rsp_reg    <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_reg     <= rr_next;
      owner_reg  <= owner_next;
      cnt_reg    <= cnt_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      gnt_reg    <= gnt_next;
      rsp_reg    <= rsp_next;
      result_reg <= result_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_found)     state_next = BUSY;
      BUSY:    if (cnt_reg == '0) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    rr_next     = rr_reg;
    owner_next  = owner_reg;
    cnt_next    = cnt_reg;
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    gnt_next    = '0;
    rsp_next    = '0;
    result_next = '0;
    busy_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          gnt_next   = NUM_REQ'(1) << win_idx;
          opa_next   = opa_slice[win_idx];
          opb_next   = opb_slice[win_idx];
          owner_next = win_idx;
          cnt_next   = CW'(MUL_LAT - 1);
          busy_next  = 1'b1;
          rr_next    = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      BUSY: begin
        if (cnt_reg != '0) begin
          cnt_next  = cnt_reg - 1'b1;
          busy_next = 1'b1;
        end else begin
          result_next = full_prod[WIDTH-1:0];
          rsp_next    = NUM_REQ'(1) << owner_reg;
        end
      end
      default: ;
    endcase
  end

  assign bus.gnt       = gnt_reg;
  assign bus.rsp_valid = rsp_reg;
  assign bus.result    = result_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched: stimulus queues expected grants and
// results, independent monitors pop and compare when the DUT pulses them.
module tb_mul_share_sched;
  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 2;

  typedef struct {
    logic [N-1:0] who;
    logic [W-1:0] val;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [N-1:0] exp_gnt_q [$];
  rsp_t         exp_rsp_q [$];

  mul_share_sched_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  mul_share_sched #(.WIDTH(W), .NUM_REQ(N), .MUL_LAT(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [N-1:0] who, input logic [W-1:0] val);
    rsp_t r;
    r.who = who;
    r.val = val;
    return r;
  endfunction

  // Grant monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        if (exp_gnt_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_gnt: got %b expected none", bus.gnt);
        end else begin
          logic [N-1:0] e;
          e = exp_gnt_q.pop_front();
          chk("gnt", 64'(bus.gnt), 64'(e));
          $display("gnt %b (expected %b) busy=%b", bus.gnt, e, bus.busy);
        end
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin
        if (exp_rsp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got %b/%0h expected none", bus.rsp_valid, bus.result);
        end else begin
          rsp_t e;
          e = exp_rsp_q.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.who));
          chk("result", 64'(bus.result), 64'(e.val));
          $display("rsp %b result %0d (expected %b %0d)", bus.rsp_valid,
                   $signed(bus.result), e.who, $signed(e.val));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Waits for n grant pulses; returns at posedge+1 of the last grant cycle.
  task automatic wait_grants(input int n, input bit spacing);
    int seen = 0;
    int cyc  = 0;
    int last = -1;
    while (seen < n && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.gnt != '0) begin
        if (spacing && last >= 0) chk("gnt_spacing", 64'(cyc - last), 64'(L + 1));
        last = cyc;
        seen++;
      end
    end
    if (seen < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_timeout: got %0d grants expected %0d", seen, n);
    end
  endtask

  task automatic single_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] prod, input bit push_rsp);
    logic [N-1:0] oh;
    oh = N'(1) << i;
    exp_gnt_q.push_back(oh);
    if (push_rsp) exp_rsp_q.push_back(mk(oh, prod));
    bus.opa[i*W +: W] = a;
    bus.opb[i*W +: W] = b;
    bus.req[i] = 1'b1;
    wait_grants(1, 1'b0);
    bus.req[i] = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.opa = '0;
    bus.opb = '0;
    #1;
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);

    // Single op with busy window
    single_op(1, 32'd7, -32'sd3, -32'sd21, 1'b1);
    chk("busy_T", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    chk("busy_T1", 64'(bus.busy), 64'd1);
    chk("rsp_T1", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("busy_T2", 64'(bus.busy), 64'd0);
    chk("rsp_T2", 64'(bus.rsp_valid), 64'b0010);
    idle(3);

    // Truncation
    single_op(2, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
    idle(4);
    single_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1);
    idle(4);

    // Operand change after grant is ignored
    single_op(3, 32'd100, 32'd5, 32'd500, 1'b1);
    @(posedge clk);
    #2;
    bus.opa[3*W +: W] = 32'd9;
    bus.opb[3*W +: W] = 32'd9;
    idle(4);

    // Reset mid-op: grant expected, response discarded
    single_op(1, 32'd3, 32'd4, 32'd12, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 64'(bus.gnt), 64'd0);
    chk("midrst_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(5);

    // Round-robin from rr_ptr=0 with all requests held
    for (int i = 0; i < N; i++) begin
      bus.opa[i*W +: W] = W'(i + 2);
      bus.opb[i*W +: W] = -W'(i + 10);
    end
    exp_gnt_q.push_back(4'b0001); exp_rsp_q.push_back(mk(4'b0001, -32'sd20));
    exp_gnt_q.push_back(4'b0010); exp_rsp_q.push_back(mk(4'b0010, -32'sd33));
    exp_gnt_q.push_back(4'b0100); exp_rsp_q.push_back(mk(4'b0100, -32'sd48));
    exp_gnt_q.push_back(4'b1000); exp_rsp_q.push_back(mk(4'b1000, -32'sd65));
    exp_gnt_q.push_back(4'b0001); exp_rsp_q.push_back(mk(4'b0001, -32'sd20));
    bus.req = 4'b1111;
    wait_grants(5, 1'b1);
    bus.req = '0;
    idle(5);

    // Fairness: rr_ptr=1, req 0 and 2 held, req 1 raised late
    bus.opa[0*W +: W] = 32'd6;          bus.opb[0*W +: W] = 32'd7;
    bus.opa[1*W +: W] = -32'sd8;        bus.opb[1*W +: W] = 32'd9;
    bus.opa[2*W +: W] = 32'h7FFF_FFFF;  bus.opb[2*W +: W] = 32'd2;
    exp_gnt_q.push_back(4'b0100); exp_rsp_q.push_back(mk(4'b0100, 32'hFFFF_FFFE));
    exp_gnt_q.push_back(4'b0001); exp_rsp_q.push_back(mk(4'b0001, 32'd42));
    exp_gnt_q.push_back(4'b0100); exp_rsp_q.push_back(mk(4'b0100, 32'hFFFF_FFFE));
    exp_gnt_q.push_back(4'b0001); exp_rsp_q.push_back(mk(4'b0001, 32'd42));
    exp_gnt_q.push_back(4'b0010); exp_rsp_q.push_back(mk(4'b0010, -32'sd72));
    exp_gnt_q.push_back(4'b0100); exp_rsp_q.push_back(mk(4'b0100, 32'hFFFF_FFFE));
    exp_gnt_q.push_back(4'b0001); exp_rsp_q.push_back(mk(4'b0001, 32'd42));
    bus.req = 4'b0101;
    wait_grants(4, 1'b1);
    bus.req[1] = 1'b1;
    wait_grants(3, 1'b1);
    bus.req = '0;
    idle(6);

    chk("gnt_q_drained", 64'(exp_gnt_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(exp_rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
